// File: rtl/cm3_code_flash_if.sv
// cm3_code_flash_if: AHB-Lite code-bus slave in front of a wait-stated flash.
// Reads go out as a single FCS strobe and complete WAIT_STATES+2 cycles later.
// Writes get a two-cycle ERROR response and never touch the flash.
// Optional macro CM3_CODE_LINEBUF_EN adds a one-word read line buffer
// (zero-wait hits, invalidated by FLUSH).
module cm3_code_flash_if #(
   parameter int unsigned ADDR_WIDTH  = 18,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELC,
   input  logic [31:0]           HADDRC,
   input  logic [1:0]            HTRANSC,
   input  logic                  HWRITEC,
   input  logic [2:0]            HSIZEC,
   input  logic                  HREADYC,
   output logic [31:0]           HRDATAC,
   output logic                  HREADYOUTC,
   output logic [1:0]            HRESPC,
   output logic                  EXRESPC,
   input  logic                  FLUSH,
   output logic                  FCS,
   output logic [ADDR_WIDTH-3:0] FADDR,
   input  logic [31:0]           FRDATA
);

   localparam int unsigned FAW = ADDR_WIDTH - 2;
   localparam int unsigned CW  = 3;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_ERROR = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_ERR1, S_ERR2} state_t;

   state_t           r_state, w_nxt_state;
   logic [CW-1:0]    r_cnt, w_nxt_cnt;
   logic             r_fcs, w_nxt_fcs;
   logic [FAW-1:0]   r_faddr, w_nxt_faddr;
   logic             r_hready, w_nxt_hready;
   logic [1:0]       r_resp, w_nxt_resp;
   logic             r_hit, w_nxt_hit;

   logic             w_accept;
   logic [FAW-1:0]   w_word;
   logic             w_done;
   logic             w_free;
   logic             w_hit;
   logic [31:0]      w_buf_data;
   logic             w_unused;

   assign w_accept = HSELC & HTRANSC[1] & HREADYC;
   assign w_word   = HADDRC[ADDR_WIDTH-1:2];
   // Read completion cycle: the only READ cycle with HREADYOUTC high
   assign w_done   = (r_state == S_READ) & r_hready;
   // Cycles in which a new address phase may be taken
   assign w_free   = (r_state == S_IDLE) | (r_state == S_ERR2) | w_done;
   assign w_unused = &{1'b0, HSIZEC, HTRANSC[0], HADDRC[31:ADDR_WIDTH], HADDRC[1:0], FLUSH};

`ifdef CM3_CODE_LINEBUF_EN
   logic             r_lb_valid;
   logic [FAW-1:0]   r_lb_tag;
   logic [31:0]      r_lb_data;

   assign w_hit      = r_lb_valid & (w_word == r_lb_tag);
   assign w_buf_data = r_lb_data;

   // Line buffer: fill on read completion, FLUSH takes priority over the fill
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_lb_valid <= 1'b0;
         r_lb_tag   <= '0;
         r_lb_data  <= '0;
      end else if (FLUSH) begin
         r_lb_valid <= 1'b0;
      end else if (w_done) begin
         r_lb_valid <= 1'b1;
         r_lb_tag   <= r_faddr;
         r_lb_data  <= FRDATA;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_buf_data = '0;
`endif

   // State and registered outputs
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_fcs    <= 1'b0;
         r_faddr  <= '0;
         r_hready <= 1'b1;
         r_resp   <= RESP_OKAY;
         r_hit    <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_cnt    <= w_nxt_cnt;
         r_fcs    <= w_nxt_fcs;
         r_faddr  <= w_nxt_faddr;
         r_hready <= w_nxt_hready;
         r_resp   <= w_nxt_resp;
         r_hit    <= w_nxt_hit;
      end
   end

   // Next state and next registered outputs
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cnt    = r_cnt;
      w_nxt_fcs    = 1'b0;
      w_nxt_faddr  = r_faddr;
      w_nxt_hready = 1'b1;
      w_nxt_resp   = RESP_OKAY;
      w_nxt_hit    = 1'b0;

      case (r_state)
         S_READ: begin
            if (!w_done) begin
               // Counter holds through the FCS cycle; ready rises when the
               // following cycle is the data-valid one.
               w_nxt_hready = r_fcs ? (r_cnt == CW'(0)) : (r_cnt == CW'(1));
               if (!r_fcs && (r_cnt != CW'(0)))
                  w_nxt_cnt = r_cnt - CW'(1);
            end
         end
         S_ERR1: begin
            w_nxt_state = S_ERR2;
            w_nxt_resp  = RESP_ERROR;
         end
         default: ;
      endcase

      if (w_free) begin
         w_nxt_state = S_IDLE;
         if (w_accept) begin
            if (HWRITEC) begin
               w_nxt_state  = S_ERR1;
               w_nxt_hready = 1'b0;
               w_nxt_resp   = RESP_ERROR;
            end else if (w_hit) begin
               w_nxt_hit = 1'b1;
            end else begin
               w_nxt_state  = S_READ;
               w_nxt_fcs    = 1'b1;
               w_nxt_faddr  = w_word;
               w_nxt_cnt    = CW'(WAIT_STATES);
               w_nxt_hready = 1'b0;
            end
         end
      end
   end

   // Flash data is only valid in the completion cycle, so it is steered through directly
   assign HRDATAC    = w_done ? FRDATA : (r_hit ? w_buf_data : 32'h0);
   assign HREADYOUTC = r_hready;
   assign HRESPC     = r_resp;
   assign EXRESPC    = 1'b0;
   assign FCS        = r_fcs;
   assign FADDR      = r_faddr;

endmodule
